// File: rtl/aad_pkg.sv
// aad_pkg: shared sample width default, pool FSM states and a clog2 helper
package aad_pkg;
  localparam int DATA_W_DEF = 8;
  typedef enum logic {ST_ACCUM, ST_HOLD} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/aad_window_acc.sv
// aad_window_acc: running window accumulator with sample counter
// ports: clk, rst (async, active-low), clear (sync abort), accept (sample taken this edge),
//        diff (sample), sum_next (acc + diff), window_done (accept of the last sample of a window)
module aad_window_acc
  import aad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WIN = 4,
  localparam int SUM_W = DATA_W + clog2(WIN)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [DATA_W-1:0] diff,
  output logic [SUM_W-1:0]  sum_next,
  output logic              window_done
);
  localparam int CNT_W = clog2(WIN);
  logic [SUM_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  assign sum_next = r_acc + SUM_W'(diff);
  assign window_done = accept && r_cnt == CNT_W'(WIN - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clear || window_done) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (accept) begin
      r_acc <= sum_next;
      r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/aad_window_pool.sv
// aad_window_pool: sums WIN-sample windows and tracks the minimum window sum per frame
// ports: clk, rst (async, active-low), clear (sync abort of window and frame),
//        in_valid/in_ready/in_diff (sample stream), out_valid/out_ready (result handshake),
//        out_sum/out_idx/out_last (window result), best_sum/best_idx (frame minimum so far)
module aad_window_pool
  import aad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int WIN = 4,
  parameter int NUM_WIN = 8,
  localparam int SUM_W = DATA_W + clog2(WIN),
  localparam int IDX_W = clog2(NUM_WIN)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_diff,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  out_sum,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic [SUM_W-1:0]  best_sum,
  output logic [IDX_W-1:0]  best_idx
);
  state_t r_state, w_state;
  logic w_accept, w_take, w_done, w_last_idx;
  logic [SUM_W-1:0] w_sum, r_sum, r_best_sum;
  logic [IDX_W-1:0] r_idx, r_out_idx, r_best_idx;
  logic r_last;
  assign in_ready = r_state == ST_ACCUM;
  assign out_valid = r_state == ST_HOLD;
  // clear overrides both handshakes, so neither a sample nor a result is consumed with it
  assign w_accept = in_valid && in_ready && !clear;
  assign w_take = out_valid && out_ready && !clear;
  assign w_last_idx = r_idx == IDX_W'(NUM_WIN - 1);
  assign out_sum = r_sum;
  assign out_idx = r_out_idx;
  assign out_last = r_last;
  assign best_sum = r_best_sum;
  assign best_idx = r_best_idx;
  aad_window_acc #(.DATA_W(DATA_W), .WIN(WIN)) u_acc (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .accept(w_accept),
    .diff(in_diff),
    .sum_next(w_sum),
    .window_done(w_done)
  );
  always_comb w_state = clear ? ST_ACCUM : w_done ? ST_HOLD : w_take ? ST_ACCUM : r_state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= ST_ACCUM;
    else r_state <= w_state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sum <= '0;
      r_out_idx <= '0;
      r_last <= 1'b0;
      r_best_sum <= '0;
      r_best_idx <= '0;
      r_idx <= '0;
    end else if (clear) begin
      r_idx <= '0;
      r_last <= 1'b0;
    end else begin
      if (w_done) begin
        r_sum <= w_sum;
        r_out_idx <= r_idx;
        r_last <= w_last_idx;
        // window 0 re-seeds the frame minimum; ties keep the earlier window
        if (r_idx == '0 || w_sum < r_best_sum) begin
          r_best_sum <= w_sum;
          r_best_idx <= r_idx;
        end
      end
      if (w_take) r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
    end
endmodule

// File: tb/tb_aad_window_pool.sv
// tb_aad_window_pool: directed and random windows checked against a frame-level reference model
module tb_aad_window_pool;
  logic clk = 0, rst = 0, clear = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_diff = 0;
  logic in_ready, out_valid, out_last;
  logic [9:0] out_sum, best_sum;
  logic [2:0] out_idx, best_idx;
  int n_assert = 0, n_fail = 0;
  int fsum[8];
  int m_idx = 0;

  aad_window_pool dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_diff(in_diff),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_idx(out_idx), .out_last(out_last),
    .best_sum(best_sum), .best_idx(best_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int k;
    k = 0;
    in_valid = 1;
    in_diff = d;
    while (!in_ready && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k == 50) chk("send_timeout_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  // One window: model computes its sum and the frame minimum from all sums seen this frame.
  task automatic win4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] d, input int hold, input bit up9);
    int es, bs, bi;
    es = int'(a) + int'(b) + int'(c) + int'(d);
    fsum[m_idx] = es;
    bs = fsum[0];
    bi = 0;
    for (int i = 1; i <= m_idx; i++)
      if (fsum[i] < bs) begin
        bs = fsum[i];
        bi = i;
      end
    out_ready = (hold == 0);
    send(a);
    send(b);
    send(c);
    send(d);
    chk("out_valid", 32'(out_valid), 1);
    chk("out_sum", 32'(out_sum), es);
    chk("out_idx", 32'(out_idx), m_idx);
    chk("out_last", 32'(out_last), 32'(m_idx == 7));
    chk("best_sum", 32'(best_sum), bs);
    chk("best_idx", 32'(best_idx), bi);
    chk("hold_in_ready", 32'(in_ready), 0);
    if (hold > 0) begin
      if (up9) begin
        in_valid = 1;
        in_diff = 9;
      end
      repeat (hold) begin
        @(posedge clk);
        #1;
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_sum", 32'(out_sum), es);
        chk("bp_idx", 32'(out_idx), m_idx);
        chk("bp_in_ready", 32'(in_ready), 0);
      end
      out_ready = 1;
    end
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("post_valid", 32'(out_valid), 0);
    chk("post_in_ready", 32'(in_ready), 1);
    m_idx = (m_idx + 1) % 8;
  endtask

  task automatic winsum(input int s);
    logic [7:0] q, r;
    q = 8'(s / 4);
    r = 8'(s - 3 * (s / 4));
    win4(q, q, q, r, 0, 0);
  endtask

  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_best_sum", 32'(best_sum), 0);
    chk("rst_best_idx", 32'(best_idx), 0);
    #10 rst = 1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    // frame 1: basic, max value, backpressure with a held upstream sample, then random
    win4(7, 17, 4, 0, 0, 0);
    win4(255, 255, 255, 255, 0, 0);
    win4(1, 2, 3, 4, 5, 1);
    win4(9, 1, 1, 1, 0, 0);
    repeat (4) win4(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    int'($urandom_range(0, 2)), 0);
    // frame 2: known sums, minimum 30 first seen at window 1
    winsum(50); winsum(30); winsum(30); winsum(40);
    winsum(60); winsum(35); winsum(31); winsum(90);
    chk("frame_best_sum", 32'(best_sum), 30);
    chk("frame_best_idx", 32'(best_idx), 1);
    winsum(100);
    // clear mid-window, with a sample offered in the clear cycle
    send(100);
    send(100);
    in_valid = 1;
    in_diff = 200;
    clear = 1;
    @(posedge clk);
    #1;
    clear = 0;
    in_valid = 0;
    chk("clr_in_ready", 32'(in_ready), 1);
    chk("clr_out_valid", 32'(out_valid), 0);
    m_idx = 0;
    win4(1, 1, 1, 1, 0, 0);
    // clear while holding a result, with out_ready in the same cycle
    out_ready = 0;
    send(0); send(0); send(0); send(1);
    chk("clrh_valid", 32'(out_valid), 1);
    clear = 1;
    out_ready = 1;
    @(posedge clk);
    #1;
    clear = 0;
    out_ready = 0;
    chk("clrh_out_valid", 32'(out_valid), 0);
    chk("clrh_out_last", 32'(out_last), 0);
    chk("clrh_best_sum", 32'(best_sum), 1);
    chk("clrh_best_idx", 32'(best_idx), 1);
    m_idx = 0;
    repeat (10) win4(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     int'($urandom_range(0, 2)), 0);
    // asynchronous reset between edges while holding a result
    out_ready = 0;
    send(200); send(201); send(202); send(203);
    chk("ar_valid_before", 32'(out_valid), 1);
    #3 rst = 0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 0);
    chk("ar_out_sum", 32'(out_sum), 0);
    chk("ar_out_idx", 32'(out_idx), 0);
    chk("ar_best_sum", 32'(best_sum), 0);
    chk("ar_best_idx", 32'(best_idx), 0);
    #7 rst = 1;
    @(posedge clk);
    #1;
    m_idx = 0;
    win4(5, 6, 7, 8, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
